// File: rtl/c9_response_compactor.sv
// Serial-input signature register and pattern counter for the C9 G5gat output.
// Optional C9_RESP_XMASK_EN adds resp_x, which masks unknown response bits to 0.
module c9_response_compactor #(
  parameter int              SIG_W        = 16,
  parameter logic [SIG_W-1:0] POLY        = 16'h1021,
  parameter logic [SIG_W-1:0] SEED        = 16'hFFFF,
  parameter int              NUM_PATTERNS = 16,
  parameter int              CNT_W        = 8,
  parameter logic [SIG_W-1:0] GOLDEN      = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic             resp_bit,
`ifdef C9_RESP_XMASK_EN
  input  logic             resp_x,
`endif
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  state_t           state, state_nx;
  logic             xfer, load, din, fb;
  logic [SIG_W-1:0] sig_nx;

  assign xfer = resp_valid & resp_ready;

`ifdef C9_RESP_XMASK_EN
  assign din = resp_bit & ~resp_x;
`else
  assign din = resp_bit;
`endif

  // Galois-style SISR step: shift left, fold POLY in when the feedback bit is set
  assign fb     = signature[SIG_W-1] ^ din;
  assign sig_nx = {signature[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_comb begin
    state_nx   = state;
    resp_ready = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: if (start) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
        if (xfer && pat_count == LAST_CNT) state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: if (start) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      pat_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        signature <= SEED;
        pat_count <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
      end else if (xfer) begin
        signature <= sig_nx;
        pat_count <= pat_count + CNT_W'(1);
      end
      if (state == CHECK) begin
        pass <= (signature == GOLDEN);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c9_response_compactor.sv
// Directed bench for c9_response_compactor with NUM_PATTERNS=4, GOLDEN=16'h0E1F.
module tb_c9_response_compactor;

  logic        clk = 1'b0;
  logic        rst, start, resp_valid, resp_bit;
`ifdef C9_RESP_XMASK_EN
  logic        resp_x;
`endif
  logic        resp_ready, busy, done, pass;
  logic [15:0] signature;
  logic [7:0]  pat_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  c9_response_compactor #(
    .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF),
    .NUM_PATTERNS(4), .CNT_W(8), .GOLDEN(16'h0E1F)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .resp_valid(resp_valid), .resp_bit(resp_bit),
`ifdef C9_RESP_XMASK_EN
    .resp_x(resp_x),
`endif
    .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_count(pat_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp_bit = 1'b0;
`ifdef C9_RESP_XMASK_EN
    resp_x = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    tests++;
    if ({resp_ready, busy, done, pass} !== 4'b0000 || signature !== 16'hFFFF || pat_count !== 8'd0) begin
      fails++;
      $display("FAIL reset: rdy/busy/done/pass=%b sig=%h cnt=%0d, want 0000 FFFF 0",
               {resp_ready, busy, done, pass}, signature, pat_count);
    end
    resp_valid = 1'b1;
    step(); step();
    resp_valid = 1'b0;
    tests++;
    if (signature !== 16'hFFFF || pat_count !== 8'd0 || resp_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_drop: sig=%h cnt=%0d rdy=%b, want FFFF 0 0", signature, pat_count, resp_ready);
    end
  endtask

  task automatic test_zeros();
    logic [15:0] exp [4] = '{16'hEFDF, 16'hCF9F, 16'h8F1F, 16'h0E1F};
    start = 1'b1; step(); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || resp_ready !== 1'b1 || signature !== 16'hFFFF || pat_count !== 8'd0) begin
      fails++;
      $display("FAIL start_run: busy=%b rdy=%b sig=%h cnt=%0d, want 1 1 FFFF 0", busy, resp_ready, signature, pat_count);
    end
    resp_valid = 1'b1; resp_bit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (signature !== exp[i] || pat_count !== 8'(i + 1)) begin
        fails++;
        $display("FAIL zeros_xfer%0d: sig=%h cnt=%0d, want %h %0d", i, signature, pat_count, exp[i], i + 1);
      end
    end
    tests++;
    if (resp_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL zeros_check: rdy=%b busy=%b done=%b, want 0 1 0", resp_ready, busy, done);
    end
    step();
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zeros_done: done=%b pass=%b busy=%b, want 1 1 0", done, pass, busy);
    end
    step();
    resp_valid = 1'b0;
    tests++;
    if (signature !== 16'h0E1F || pat_count !== 8'd4 || done !== 1'b1 || pass !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: sig=%h cnt=%0d done=%b pass=%b, want 0E1F 4 1 1", signature, pat_count, done, pass);
    end
  endtask

  task automatic test_ones();
    logic [15:0] exp [4] = '{16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0};
    start = 1'b1; step(); start = 1'b0;
    tests++;
    if (done !== 1'b0 || pass !== 1'b0 || signature !== 16'hFFFF || pat_count !== 8'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_from_done: done=%b pass=%b sig=%h cnt=%0d busy=%b, want 0 0 FFFF 0 1",
               done, pass, signature, pat_count, busy);
    end
    resp_valid = 1'b1; resp_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (signature !== exp[i] || pat_count !== 8'(i + 1)) begin
        fails++;
        $display("FAIL ones_xfer%0d: sig=%h cnt=%0d, want %h %0d", i, signature, pat_count, exp[i], i + 1);
      end
    end
    resp_valid = 1'b0;
    step();
    tests++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      fails++;
      $display("FAIL ones_done: done=%b pass=%b, want 1 0", done, pass);
    end
  endtask

  task automatic test_stall();
    logic [15:0] tbl [5] = '{16'hFFFF, 16'hEFDF, 16'hCF9F, 16'h8F1F, 16'h0E1F};
    logic [6:0]  vpat    = 7'b1101001;  // bit 0 applied first: 1,0,0,1,0,1,1
    int          k       = 0;
    start = 1'b1; step(); start = 1'b0;
    resp_bit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      resp_valid = vpat[i];
      step();
      if (vpat[i]) k++;
      tests++;
      if (signature !== tbl[k] || pat_count !== 8'(k)) begin
        fails++;
        $display("FAIL stall_cyc%0d: sig=%h cnt=%0d, want %h %0d", i, signature, pat_count, tbl[k], k);
      end
    end
    resp_valid = 1'b0;
    step();
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h0E1F) begin
      fails++;
      $display("FAIL stall_done: done=%b pass=%b sig=%h, want 1 1 0E1F", done, pass, signature);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; step(); start = 1'b0;
    resp_valid = 1'b1; resp_bit = 1'b0;
    step(); step();
    resp_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    tests++;
    if ({resp_ready, busy, done} !== 3'b000 || signature !== 16'hFFFF || pat_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_run: rdy/busy/done=%b sig=%h cnt=%0d, want 000 FFFF 0",
               {resp_ready, busy, done}, signature, pat_count);
    end
    resp_valid = 1'b1;
    step(); step(); step();
    resp_valid = 1'b0;
    tests++;
    if (signature !== 16'hFFFF || pat_count !== 8'd0 || done !== 1'b0 || resp_ready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_drop: sig=%h cnt=%0d done=%b rdy=%b, want FFFF 0 0 0",
               signature, pat_count, done, resp_ready);
    end
  endtask

  task automatic test_start_in_run();
    start = 1'b1; step(); start = 1'b0;
    resp_valid = 1'b1; resp_bit = 1'b0;
    step();
    resp_valid = 1'b0; start = 1'b1;
    step();
    tests++;
    if (signature !== 16'hEFDF || pat_count !== 8'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_ignored_stall: sig=%h cnt=%0d busy=%b, want EFDF 1 1", signature, pat_count, busy);
    end
    resp_valid = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (signature !== 16'hCF9F || pat_count !== 8'd2) begin
      fails++;
      $display("FAIL start_ignored_xfer: sig=%h cnt=%0d, want CF9F 2", signature, pat_count);
    end
    step(); step();
    resp_valid = 1'b0;
    step();
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h0E1F) begin
      fails++;
      $display("FAIL start_in_run_done: done=%b pass=%b sig=%h, want 1 1 0E1F", done, pass, signature);
    end
  endtask

`ifdef C9_RESP_XMASK_EN
  task automatic test_xmask();
    start = 1'b1; step(); start = 1'b0;
    resp_valid = 1'b1; resp_bit = 1'b1; resp_x = 1'b1;
    step(); step(); step(); step();
    resp_valid = 1'b0; resp_x = 1'b0;
    tests++;
    if (signature !== 16'h0E1F || pat_count !== 8'd4) begin
      fails++;
      $display("FAIL xmask_sig: sig=%h cnt=%0d, want 0E1F 4", signature, pat_count);
    end
    step();
    tests++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      fails++;
      $display("FAIL xmask_done: done=%b pass=%b, want 1 1", done, pass);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_stall();
    test_reset_mid_run();
    test_start_in_run();
`ifdef C9_RESP_XMASK_EN
    test_xmask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
